uart_rx_packet_ctrl: RTL and testbench
======================================

Name: uart_rx_packet_ctrl

Overview:
Sequences the byte stream from the UART receive path into validated packets. Frame format: SYNC, LEN, LEN payload bytes, CHK, where CHK is the XOR of LEN and all payload bytes. Payload is stored in an internal buffer and held for a downstream consumer until acknowledged. Sits between the UART byte receiver (one-cycle data-ready pulse) and the command/processing logic.

Parameters:
SYNC_BYTE, 8'hA5, start-of-frame marker.
MAX_LEN, 16, maximum payload length in bytes (>=1).
TIMEOUT_CYCLES, 50000, maximum clk cycles allowed between bytes inside a frame.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
rx_valid  in  1  one-cycle pulse; rx_byte is valid.
rx_byte  in  8  received byte.
pkt_ready  out  1  validated packet held in buffer.
pkt_len  out  $clog2(MAX_LEN+1)  payload length; valid while pkt_ready.
rd_addr  in  $clog2(MAX_LEN)  payload read index.
rd_data  out  8  buffer[rd_addr], combinational read.
pkt_ack  in  1  consumer done; releases buffer.
busy  out  1  high in any state except IDLE.
chk_err  out  1  one-cycle pulse: checksum mismatch.
len_err  out  1  one-cycle pulse: LEN = 0 or LEN > MAX_LEN.
timeout_err  out  1  one-cycle pulse: inter-byte gap exceeded.
drop_err  out  1  one-cycle pulse: byte arrived while a packet was held.

Behaviour:
- Reset: state IDLE; pkt_ready, pkt_len, busy, and all error pulses are 0; running checksum, byte index, and gap counter are 0. Buffer contents are not reset. Reset mid-frame or mid-hold discards everything.
- States: IDLE, GET_LEN, GET_DATA, GET_CHK, HOLD. Bytes are consumed only on cycles with rx_valid = 1.
- IDLE: rx_byte == SYNC_BYTE goes to GET_LEN. Any other byte is ignored silently.
- GET_LEN:
  - LEN in 1..MAX_LEN: latch LEN, chk <= LEN, idx <= 0, go to GET_DATA.
  - Otherwise: pulse len_err, go to IDLE.
  - A SYNC_BYTE value here is treated as LEN; no resync.
- GET_DATA: buffer[idx] <= byte, chk <= chk ^ byte, idx <= idx+1. Go to GET_CHK when idx == LEN-1.
- GET_CHK:
  - byte == chk: go to HOLD, pkt_ready = 1 starting the cycle after the CHK rx_valid (latency 1), pkt_len = LEN.
  - Mismatch: pulse chk_err, go to IDLE, pkt_ready stays 0.
- HOLD: pkt_ready = 1 and the buffer is frozen.
  - rx_valid: byte discarded, pulse drop_err.
  - pkt_ack: pkt_ready = 0 next cycle, go to IDLE.
  - rx_valid and pkt_ack in the same cycle: byte dropped with drop_err, then go to IDLE.
  - pkt_ack outside HOLD is ignored.
- Gap timer: active in GET_LEN, GET_DATA, and GET_CHK.
  - Cleared on every rx_valid and on entry from IDLE; increments otherwise.
  - On reaching TIMEOUT_CYCLES-1 without rx_valid: pulse timeout_err, go to IDLE.
  - rx_valid coinciding with expiry: the byte is processed and the timer is cleared (rx_valid wins).
- Error pulses last exactly one cycle. At most one error fires per cycle.
- Arithmetic: idx and timer counters never wrap because the state exit precedes overflow. rd_addr >= pkt_len returns stale buffer data (don't-care).

Decomposition:
- Package uart_rx_pkt_pkg: state enum encoding (3-bit localparams), default SYNC_BYTE, and the length-width function.
- One sub-module, rx_gap_timer, holding the cleared-on-byte down-counter with an expire pulse and an enable input.
- Buffer is an inline register array with no RAM macro.

Test Plan:
- Good frame: rx_valid bytes A5 03 11 22 33 03 with 10-cycle gaps -> pkt_ready = 1 one cycle after the last byte; pkt_len = 3; rd_addr 0/1/2 -> 11/22/33; pkt_ack -> pkt_ready = 0 next cycle, busy = 0.
- Bad checksum: A5 02 AA 55 00 -> chk_err single pulse, pkt_ready never asserts; the subsequent good frame A5 01 7E 7F is accepted with pkt_len = 1 and rd_data[0] = 7E.
- Length errors: A5 00 -> len_err; A5 11 (17 > MAX_LEN) -> len_err; state back to IDLE each time. Also send 33 A5 01 0F 0E -> leading 33 ignored, packet accepted.
- Timeout: A5 04 10 then no byte for TIMEOUT_CYCLES (set to 100 in the bench) -> timeout_err after exactly 99 idle cycles. Repeat with rx_valid arriving on the expiry cycle -> no timeout_err, frame continues.
- Hold overrun: complete a good frame, send 5A without ack -> drop_err pulse, buffer and pkt_len unchanged. Then ack in the same cycle as rx_valid -> drop_err pulse and IDLE.
- Reset mid-frame: assert rst for 1 cycle after A5 02 10 -> busy = 0 and all outputs 0; the next full frame is accepted normally.

Source files
------------

// File: rtl/uart_rx_pkt_pkg.sv
// Shared types and helpers for the UART receive packet controller.
package uart_rx_pkt_pkg;

  localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
  localparam logic [2:0] ST_GET_LEN_ENC  = 3'd1;
  localparam logic [2:0] ST_GET_DATA_ENC = 3'd2;
  localparam logic [2:0] ST_GET_CHK_ENC  = 3'd3;
  localparam logic [2:0] ST_HOLD_ENC     = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_GET_LEN  = ST_GET_LEN_ENC,
    ST_GET_DATA = ST_GET_DATA_ENC,
    ST_GET_CHK  = ST_GET_CHK_ENC,
    ST_HOLD     = ST_HOLD_ENC
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Width needed to hold a payload length of 0..max_len.
  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Width of a payload index; never narrower than one bit.
  function automatic int addr_width(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_packet_ctrl_gap_timer.sv
// Inter-byte gap timer: down-counter reloaded on every byte or while idle,
// expire pulses when TIMEOUT_CYCLES-1 quiet cycles have elapsed.
module rx_gap_timer
  import uart_rx_pkt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Reload while disabled or on a byte, otherwise count down toward zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || clr) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Expiry is the last quiet cycle; a byte on that cycle suppresses it.
  assign expire = en && !clr && (cnt_q == TW'(1));

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= LOAD;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// Frames the UART byte stream (SYNC, LEN, payload, CHK) into validated
// packets held in an internal buffer until the consumer acknowledges.
//
// state       | meaning
// ST_IDLE     | waiting for SYNC_BYTE
// ST_GET_LEN  | next byte is the payload length
// ST_GET_DATA | collecting payload bytes into the buffer
// ST_GET_CHK  | next byte is the XOR checksum
// ST_HOLD     | validated packet held until pkt_ack
module uart_rx_packet_ctrl
  import uart_rx_pkt_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx_valid,
  input  logic [7:0]                       rx_byte,
  output logic                             pkt_ready,
  output logic [len_width(MAX_LEN)-1:0]    pkt_len,
  input  logic [addr_width(MAX_LEN)-1:0]   rd_addr,
  output logic [7:0]                       rd_data,
  input  logic                             pkt_ack,
  output logic                             busy,
  output logic                             chk_err,
  output logic                             len_err,
  output logic                             timeout_err,
  output logic                             drop_err
);

  localparam int LW = len_width(MAX_LEN);
  localparam int AW = addr_width(MAX_LEN);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]    chk_q, chk_d;
  logic          chk_err_q, chk_err_d;
  logic          len_err_q, len_err_d;
  logic          timeout_err_q, timeout_err_d;
  logic          drop_err_q, drop_err_d;
  logic          wr_en;
  logic          timer_en;
  logic          gap_expire;
  logic [7:0]    buf_mem_q [MAX_LEN];

  assign timer_en = (state_q == ST_GET_LEN) || (state_q == ST_GET_DATA) ||
                    (state_q == ST_GET_CHK);

  rx_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (timer_en),
    .clr   (rx_valid),
    .expire(gap_expire)
  );

  // Next-state, frame bookkeeping and error pulse generation.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    chk_d         = chk_q;
    chk_err_d     = 1'b0;
    len_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    drop_err_d    = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) state_d = ST_GET_LEN;
      end
      ST_GET_LEN: begin
        if (rx_valid) begin
          if ((rx_byte != 8'd0) && (rx_byte <= MAX_LEN_B)) begin
            len_d   = LW'(rx_byte);
            chk_d   = rx_byte;
            idx_d   = '0;
            state_d = ST_GET_DATA;
          end else begin
            len_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end else if (gap_expire) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_GET_DATA: begin
        if (rx_valid) begin
          wr_en = 1'b1;
          chk_d = chk_q ^ rx_byte;
          idx_d = idx_q + LW'(1);
          if (idx_q == (len_q - LW'(1))) state_d = ST_GET_CHK;
        end else if (gap_expire) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_GET_CHK: begin
        if (rx_valid) begin
          if (rx_byte == chk_q) begin
            state_d = ST_HOLD;
          end else begin
            chk_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end else if (gap_expire) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Buffer stays frozen; any byte arriving now is lost.
        if (rx_valid) drop_err_d = 1'b1;
        if (pkt_ack)  state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      chk_q         <= '0;
      chk_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      drop_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      chk_err_q     <= chk_err_d;
      len_err_q     <= len_err_d;
      timeout_err_q <= timeout_err_d;
      drop_err_q    <= drop_err_d;
    end
  end

  // Payload buffer; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem_q[idx_q[AW-1:0]] <= rx_byte;
  end

  assign rd_data     = buf_mem_q[rd_addr];
  assign pkt_ready   = (state_q == ST_HOLD);
  assign pkt_len     = len_q;
  assign busy        = (state_q != ST_IDLE);
  assign chk_err     = chk_err_q;
  assign len_err     = len_err_q;
  assign timeout_err = timeout_err_q;
  assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Directed bench for uart_rx_packet_ctrl with a short gap timeout.
module tb_uart_rx_packet_ctrl;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       pkt_ready;
  logic [4:0] pkt_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       pkt_ack;
  logic       busy;
  logic       chk_err;
  logic       len_err;
  logic       timeout_err;
  logic       drop_err;

  int total = 0;
  int bad   = 0;

  uart_rx_packet_ctrl #(
    .SYNC_BYTE     (8'hA5),
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .pkt_ready  (pkt_ready),
    .pkt_len    (pkt_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pkt_ack    (pkt_ack),
    .busy       (busy),
    .chk_err    (chk_err),
    .len_err    (len_err),
    .timeout_err(timeout_err),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; rd_addr = 4'd0; pkt_ack = 1'b0;
    idle(2);
    rst = 1'b0;
    tick();
    check("rst_ready", 32'(pkt_ready), 32'd0);
    check("rst_len",   32'(pkt_len),   32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_errs",  32'({chk_err, len_err, timeout_err, drop_err}), 32'd0);

    // Good frame with 10-cycle gaps.
    send(8'hA5); idle(10);
    check("gf_busy", 32'(busy), 32'd1);
    send(8'h03); idle(10);
    send(8'h11); idle(10);
    send(8'h22); idle(10);
    send(8'h33); idle(10);
    check("gf_ready_pre", 32'(pkt_ready), 32'd0);
    send(8'h03);
    check("gf_ready", 32'(pkt_ready), 32'd1);
    check("gf_len",   32'(pkt_len),   32'd3);
    check_rd("gf_rd0", 4'd0, 8'h11);
    check_rd("gf_rd1", 4'd1, 8'h22);
    check_rd("gf_rd2", 4'd2, 8'h33);
    idle(3);
    check("gf_hold", 32'(pkt_ready), 32'd1);
    pkt_ack = 1'b1; tick(); pkt_ack = 1'b0;
    check("gf_ack_ready", 32'(pkt_ready), 32'd0);
    check("gf_ack_busy",  32'(busy),      32'd0);

    // Bad checksum, then a good one-byte frame.
    send(8'hA5); send(8'h02); send(8'hAA); send(8'h55); send(8'h00);
    check("bc_err",   32'(chk_err),   32'd1);
    check("bc_ready", 32'(pkt_ready), 32'd0);
    check("bc_busy",  32'(busy),      32'd0);
    tick();
    check("bc_pulse", 32'(chk_err), 32'd0);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    check("bc2_ready", 32'(pkt_ready), 32'd1);
    check("bc2_len",   32'(pkt_len),   32'd1);
    check_rd("bc2_rd0", 4'd0, 8'h7E);
    pkt_ack = 1'b1; tick(); pkt_ack = 1'b0;

    // Length errors and a leading junk byte.
    send(8'hA5); send(8'h00);
    check("le0_err",  32'(len_err), 32'd1);
    check("le0_busy", 32'(busy),    32'd0);
    tick();
    check("le0_pulse", 32'(len_err), 32'd0);
    send(8'hA5); send(8'h11);
    check("le17_err",  32'(len_err), 32'd1);
    check("le17_busy", 32'(busy),    32'd0);
    send(8'hA5); send(8'h10);
    check("le16_ok", 32'({busy, len_err}), 32'h2);
    rst = 1'b1; tick(); rst = 1'b0;
    send(8'h33);
    check("junk_busy", 32'(busy), 32'd0);
    send(8'hA5); send(8'h01); send(8'h0F); send(8'h0E);
    check("junk_ready", 32'(pkt_ready), 32'd1);
    check("junk_len",   32'(pkt_len),   32'd1);
    check_rd("junk_rd0", 4'd0, 8'h0F);

    // Hold overrun, then ack coinciding with a byte.
    send(8'h5A);
    check("ov_drop",  32'(drop_err),  32'd1);
    check("ov_ready", 32'(pkt_ready), 32'd1);
    check("ov_len",   32'(pkt_len),   32'd1);
    check_rd("ov_rd0", 4'd0, 8'h0F);
    tick();
    check("ov_pulse", 32'(drop_err), 32'd0);
    pkt_ack = 1'b1; send(8'h5B); pkt_ack = 1'b0;
    check("ova_drop",  32'(drop_err),  32'd1);
    check("ova_ready", 32'(pkt_ready), 32'd0);
    check("ova_busy",  32'(busy),      32'd0);
    tick();

    // Timeout after exactly TIMEOUT-1 quiet cycles.
    send(8'hA5); send(8'h04); send(8'h10);
    idle(TIMEOUT - 2);
    check("to_early_err",  32'(timeout_err), 32'd0);
    check("to_early_busy", 32'(busy),        32'd1);
    tick();
    check("to_err",  32'(timeout_err), 32'd1);
    check("to_busy", 32'(busy),        32'd0);
    tick();
    check("to_pulse", 32'(timeout_err), 32'd0);

    // Byte on the expiry cycle wins and the frame continues.
    send(8'hA5); send(8'h04); send(8'h10);
    idle(TIMEOUT - 2);
    send(8'h20);
    check("tw_err",  32'(timeout_err), 32'd0);
    check("tw_busy", 32'(busy),        32'd1);
    idle(TIMEOUT - 2);
    send(8'h30);
    check("tw2_err", 32'(timeout_err), 32'd0);
    send(8'h40); send(8'h44);
    check("tw_ready", 32'(pkt_ready), 32'd1);
    check("tw_len",   32'(pkt_len),   32'd4);
    check_rd("tw_rd3", 4'd3, 8'h40);
    pkt_ack = 1'b1; tick(); pkt_ack = 1'b0;

    // Reset mid-frame discards everything.
    send(8'hA5); send(8'h02); send(8'h10);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mr_busy",  32'(busy),      32'd0);
    check("mr_ready", 32'(pkt_ready), 32'd0);
    check("mr_len",   32'(pkt_len),   32'd0);
    check("mr_errs",  32'({chk_err, len_err, timeout_err, drop_err}), 32'd0);
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h32);
    check("mr_ok_ready", 32'(pkt_ready), 32'd1);
    check("mr_ok_len",   32'(pkt_len),   32'd2);
    check_rd("mr_rd0", 4'd0, 8'h10);
    check_rd("mr_rd1", 4'd1, 8'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
